mem_fill_arbiter: RTL and testbench

- Sequences cache-line refills from the shared, multi-cycle, pipelined main memory on a miss.
- Arbitrates between two requesters: the instruction-side miss (from fetch/I-cache) and the data-side miss (from memory stage/D-cache).
- Issues burst reads, steers returned words into the owning cache's fill port, and signals fill completion so the hazard unit can release the stall.

---
 rtl/mem_fill_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_fill_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: arbitrates I-side and D-side cache-line refills onto a pipelined main memory.
// Build option ROUND_ROBIN_EN: alternate grants under contention (default build: fixed D-over-I).
module mem_fill_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned OFF_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I_miss,
  input  logic [15:0]      I_miss_addr,
  input  logic             D_miss,
  input  logic [15:0]      D_miss_addr,
  output logic             mem_en,
  output logic [15:0]      mem_addr,
  input  logic             mem_data_valid,
  input  logic [15:0]      mem_data,
  output logic [15:0]      fill_data,
  output logic [OFF_W-1:0] fill_word,
  output logic             fill_we_I,
  output logic             fill_we_D,
  output logic             I_fill_done,
  output logic             D_fill_done,
  output logic             busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               owner_d, owner_d_nxt;
  logic [TAG_W-1:0]   base_tag, base_tag_nxt;
  logic [CNT_W-1:0]   issue_cnt, issue_cnt_nxt;
  logic [CNT_W-1:0]   recv_cnt, recv_cnt_nxt;
  logic               mem_en_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [15:0]        fill_data_nxt;
  logic [OFF_W-1:0]   fill_word_nxt;
  logic               fill_we_i_nxt, fill_we_d_nxt;
  logic               i_done_nxt, d_done_nxt;
  logic               busy_nxt;
  logic               grant_d, grant_i;
`ifdef ROUND_ROBIN_EN
  logic               prio_d, prio_d_nxt;
`endif

  // Line offset and byte-select bits of the miss addresses are implied by the burst
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_miss_addr[OFF_W:0], D_miss_addr[OFF_W:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner_d     <= 1'b1;
      base_tag    <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      fill_data   <= '0;
      fill_word   <= '0;
      fill_we_I   <= 1'b0;
      fill_we_D   <= 1'b0;
      I_fill_done <= 1'b0;
      D_fill_done <= 1'b0;
      busy        <= 1'b0;
`ifdef ROUND_ROBIN_EN
      prio_d      <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      owner_d     <= owner_d_nxt;
      base_tag    <= base_tag_nxt;
      issue_cnt   <= issue_cnt_nxt;
      recv_cnt    <= recv_cnt_nxt;
      mem_en      <= mem_en_nxt;
      mem_addr    <= mem_addr_nxt;
      fill_data   <= fill_data_nxt;
      fill_word   <= fill_word_nxt;
      fill_we_I   <= fill_we_i_nxt;
      fill_we_D   <= fill_we_d_nxt;
      I_fill_done <= i_done_nxt;
      D_fill_done <= d_done_nxt;
      busy        <= busy_nxt;
`ifdef ROUND_ROBIN_EN
      prio_d      <= prio_d_nxt;
`endif
    end
  end

  // Next-state and registered-output logic; the first burst word issues in the grant cycle
  always_comb begin
    state_nxt     = state;
    owner_d_nxt   = owner_d;
    base_tag_nxt  = base_tag;
    issue_cnt_nxt = issue_cnt;
    recv_cnt_nxt  = recv_cnt;
    mem_en_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    fill_data_nxt = fill_data;
    fill_word_nxt = fill_word;
    fill_we_i_nxt = 1'b0;
    fill_we_d_nxt = 1'b0;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    grant_d       = 1'b0;
    grant_i       = 1'b0;
`ifdef ROUND_ROBIN_EN
    prio_d_nxt    = prio_d;
`endif

    case (state)
      S_IDLE: begin
`ifdef ROUND_ROBIN_EN
        grant_d = D_miss && (!I_miss || prio_d);
`else
        grant_d = D_miss;
`endif
        grant_i = I_miss && !grant_d;
        if (grant_d || grant_i) begin
          owner_d_nxt   = grant_d;
          base_tag_nxt  = grant_d ? D_miss_addr[ADDR_W-1:OFF_W+1] : I_miss_addr[ADDR_W-1:OFF_W+1];
          mem_en_nxt    = 1'b1;
          mem_addr_nxt  = {base_tag_nxt, {OFF_W{1'b0}}, 1'b0};
          issue_cnt_nxt = CNT_W'(1);
          recv_cnt_nxt  = '0;
          state_nxt     = S_FILL;
`ifdef ROUND_ROBIN_EN
          prio_d_nxt    = !grant_d;
`endif
        end
      end
      S_FILL: begin
        if (issue_cnt != CNT_FULL) begin
          mem_en_nxt    = 1'b1;
          mem_addr_nxt  = {base_tag, issue_cnt[OFF_W-1:0], 1'b0};
          issue_cnt_nxt = issue_cnt + CNT_W'(1);
        end
        if (mem_data_valid) begin
          fill_data_nxt = mem_data;
          fill_word_nxt = recv_cnt[OFF_W-1:0];
          fill_we_d_nxt = owner_d;
          fill_we_i_nxt = !owner_d;
          recv_cnt_nxt  = recv_cnt + CNT_W'(1);
          if (recv_cnt == CNT_LAST) begin
            state_nxt  = S_DONE;
            d_done_nxt = owner_d;
            i_done_nxt = !owner_d;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: directed bench for mem_fill_arbiter with an in-order, fixed-latency memory model.
`timescale 1ns/1ps
module tb_mem_fill_arbiter;

  localparam int unsigned OFF_W = 3;
  localparam int LAT = 4;
  localparam int OBS_MAX = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             I_miss, D_miss;
  logic [15:0]      I_miss_addr, D_miss_addr;
  logic             mem_en;
  logic [15:0]      mem_addr;
  logic             mem_data_valid;
  logic [15:0]      mem_data;
  logic [15:0]      fill_data;
  logic [OFF_W-1:0] fill_word;
  logic             fill_we_I, fill_we_D, I_fill_done, D_fill_done, busy;

  int total = 0;
  int bad = 0;

  mem_fill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_miss(I_miss), .I_miss_addr(I_miss_addr),
    .D_miss(D_miss), .D_miss_addr(D_miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_I(fill_we_I), .fill_we_D(fill_we_D),
    .I_fill_done(I_fill_done), .D_fill_done(D_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: return data = addr ^ 5A5A, LAT cycles after issue; optional stall before word 4 of a line
  logic [15:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0;
  int          gap_len = 0;
  int          gap_wait = 0;
  logic        inj_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_addr.delete();
      q_due.delete();
      mem_data_valid = 1'b0;
      mem_data = 16'h0;
    end else begin
      if (mem_en) begin
        q_addr.push_back(mem_addr);
        q_due.push_back(cyc + LAT);
      end
      mem_data_valid = inj_valid;
      mem_data = inj_valid ? 16'hDEAD : 16'h0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        if (gap_len > 0 && q_addr[0][3:1] == 3'd4 && gap_wait < gap_len) begin
          gap_wait++;
        end else begin
          if (q_addr[0][3:1] == 3'd4) gap_wait = 0;
          mem_data_valid = 1'b1;
          mem_data = q_addr.pop_front() ^ 16'h5A5A;
          void'(q_due.pop_front());
        end
      end
    end
  end

  // Per-cycle record of DUT outputs, one entry per falling edge
  logic             o_en[OBS_MAX];
  logic [15:0]      o_addr[OBS_MAX];
  logic             o_we_i[OBS_MAX];
  logic             o_we_d[OBS_MAX];
  logic [OFF_W-1:0] o_word[OBS_MAX];
  logic [15:0]      o_data[OBS_MAX];
  logic             o_done_i[OBS_MAX];
  logic             o_done_d[OBS_MAX];
  logic             o_busy[OBS_MAX];
  int               obs_n;
  logic             auto_drop;

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (obs_n < OBS_MAX) begin
        o_en[obs_n] = mem_en;       o_addr[obs_n] = mem_addr;
        o_we_i[obs_n] = fill_we_I;  o_we_d[obs_n] = fill_we_D;
        o_word[obs_n] = fill_word;  o_data[obs_n] = fill_data;
        o_done_i[obs_n] = I_fill_done; o_done_d[obs_n] = D_fill_done;
        o_busy[obs_n] = busy;
        obs_n++;
      end
      if (auto_drop && I_fill_done) I_miss = 1'b0;
      if (auto_drop && D_fill_done) D_miss = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; I_miss = 1'b0; D_miss = 1'b0; I_miss_addr = '0; D_miss_addr = '0;
    auto_drop = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_en, fill_we_I, fill_we_D, I_fill_done, D_fill_done, busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {mem_en, fill_we_I, fill_we_D, I_fill_done, D_fill_done, busy});
    end
    total++;
    if ({mem_addr, fill_data, fill_word} !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%h data=%h word=%0d want zeros", mem_addr, fill_data, fill_word);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_i();
    int n_we_d, n_done;
    obs_n = 0; I_miss_addr = 16'h0046; I_miss = 1'b1;
    observe(16);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (o_en[k] !== 1'b1 || o_addr[k] !== 16'h0040 + 16'(2 * k)) begin
        bad++; $display("FAIL basic_issue[%0d]: got en=%b addr=%h want en=1 addr=%h", k, o_en[k], o_addr[k], 16'h0040 + 16'(2 * k));
      end
      total++;
      if (o_we_i[5+k] !== 1'b1 || o_word[5+k] !== 3'(k) || o_data[5+k] !== ((16'h0040 + 16'(2 * k)) ^ 16'h5A5A)) begin
        bad++; $display("FAIL basic_fill[%0d]: got we=%b word=%0d data=%h want we=1 word=%0d data=%h", k, o_we_i[5+k], o_word[5+k], o_data[5+k], k, (16'h0040 + 16'(2 * k)) ^ 16'h5A5A);
      end
    end
    total++;
    if (o_en[8] !== 1'b0) begin bad++; $display("FAIL basic_issue_end: got en=%b want 0", o_en[8]); end
    n_we_d = 0; n_done = 0;
    for (int k = 0; k < 16; k++) begin
      if (o_we_d[k]) n_we_d++;
      if (o_done_i[k]) n_done++;
    end
    total++;
    if (n_we_d != 0) begin bad++; $display("FAIL basic_we_d: got %0d pulses want 0", n_we_d); end
    total++;
    if (o_done_i[12] !== 1'b1 || n_done != 1) begin
      bad++; $display("FAIL basic_done: got done@12=%b count=%0d want 1 and 1", o_done_i[12], n_done);
    end
    total++;
    if (o_busy[12] !== 1'b1 || o_busy[13] !== 1'b0) begin
      bad++; $display("FAIL basic_busy: got %b%b want 10", o_busy[12], o_busy[13]);
    end
  endtask

  task automatic test_contention();
    int n_we_i_early, n_we_d;
    obs_n = 0;
    I_miss_addr = 16'h1000; D_miss_addr = 16'h2008; I_miss = 1'b1; D_miss = 1'b1;
    observe(30);
    total++;
    if (o_en[0] !== 1'b1 || o_addr[0] !== 16'h2000 || o_addr[7] !== 16'h200E) begin
      bad++; $display("FAIL cont_d_issue: got en=%b first=%h last=%h want 1 2000 200e", o_en[0], o_addr[0], o_addr[7]);
    end
    total++;
    if (o_done_d[12] !== 1'b1) begin bad++; $display("FAIL cont_d_done: got %b want 1", o_done_d[12]); end
    total++;
    if (o_busy[13] !== 1'b0 || o_en[13] !== 1'b0) begin
      bad++; $display("FAIL cont_idle_gap: got busy=%b en=%b want 0 0", o_busy[13], o_en[13]);
    end
    total++;
    if (o_en[14] !== 1'b1 || o_addr[14] !== 16'h1000 || o_addr[21] !== 16'h100E) begin
      bad++; $display("FAIL cont_i_issue: got en=%b first=%h last=%h want 1 1000 100e", o_en[14], o_addr[14], o_addr[21]);
    end
    total++;
    if (o_done_i[26] !== 1'b1) begin bad++; $display("FAIL cont_i_done: got %b want 1", o_done_i[26]); end
    n_we_i_early = 0; n_we_d = 0;
    for (int k = 0; k < 30; k++) begin
      if (o_we_i[k] && k < 14) n_we_i_early++;
      if (o_we_d[k]) n_we_d++;
    end
    total++;
    if (n_we_i_early != 0 || n_we_d != 8) begin
      bad++; $display("FAIL cont_we_count: got we_i_during_d=%0d we_d=%0d want 0 8", n_we_i_early, n_we_d);
    end
  endtask

  task automatic test_top_addr();
    int n_en, n_zero, n_we;
    obs_n = 0; D_miss_addr = 16'hFFFE; D_miss = 1'b1;
    observe(16);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (o_en[k] !== 1'b1 || o_addr[k] !== 16'hFFF0 + 16'(2 * k)) begin
        bad++; $display("FAIL top_issue[%0d]: got en=%b addr=%h want en=1 addr=%h", k, o_en[k], o_addr[k], 16'hFFF0 + 16'(2 * k));
      end
    end
    n_en = 0; n_zero = 0; n_we = 0;
    for (int k = 0; k < 16; k++) begin
      if (o_en[k]) n_en++;
      if (o_en[k] && o_addr[k] == 16'h0000) n_zero++;
      if (o_we_d[k]) n_we++;
    end
    total++;
    if (n_en != 8 || n_zero != 0) begin bad++; $display("FAIL top_wrap: got issues=%0d at_zero=%0d want 8 0", n_en, n_zero); end
    total++;
    if (n_we != 8 || o_done_d[12] !== 1'b1) begin
      bad++; $display("FAIL top_done: got we=%0d done@12=%b want 8 1", n_we, o_done_d[12]);
    end
  endtask

  task automatic test_gap();
    int n_we;
    obs_n = 0; gap_len = 3; I_miss_addr = 16'h0200; I_miss = 1'b1;
    observe(20);
    gap_len = 0;
    total++;
    if (o_we_i[8] !== 1'b1 || o_word[8] !== 3'd3) begin
      bad++; $display("FAIL gap_word3: got we=%b word=%0d want 1 3", o_we_i[8], o_word[8]);
    end
    total++;
    if ({o_we_i[9], o_we_i[10], o_we_i[11], o_we_d[9], o_we_d[10], o_we_d[11]} !== 6'b0) begin
      bad++; $display("FAIL gap_quiet: got we_i=%b%b%b want 000", o_we_i[9], o_we_i[10], o_we_i[11]);
    end
    total++;
    if (o_we_i[12] !== 1'b1 || o_word[12] !== 3'd4 || o_data[12] !== (16'h0208 ^ 16'h5A5A)) begin
      bad++; $display("FAIL gap_resume: got we=%b word=%0d data=%h want 1 4 %h", o_we_i[12], o_word[12], o_data[12], 16'h0208 ^ 16'h5A5A);
    end
    n_we = 0;
    for (int k = 0; k < 20; k++) if (o_we_i[k]) n_we++;
    total++;
    if (o_done_i[15] !== 1'b1 || o_done_i[12] !== 1'b0 || o_word[15] !== 3'd7 || n_we != 8) begin
      bad++; $display("FAIL gap_done: got done@15=%b done@12=%b word@15=%0d we=%0d want 1 0 7 8", o_done_i[15], o_done_i[12], o_word[15], n_we);
    end
  endtask

  task automatic test_reset_mid();
    int n_act;
    obs_n = 0; I_miss_addr = 16'h0134; I_miss = 1'b1;
    observe(9);
    total++;
    if (o_we_i[8] !== 1'b1 || o_word[8] !== 3'd3) begin
      bad++; $display("FAIL rmid_pre: got we=%b word=%0d want 1 3", o_we_i[8], o_word[8]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_en, fill_we_I, fill_we_D, I_fill_done, D_fill_done, busy} !== 6'b0 || {mem_addr, fill_data, fill_word} !== '0) begin
      bad++; $display("FAIL rmid_async: got ctrl=%b addr=%h data=%h want all zero", {mem_en, fill_we_I, fill_we_D, I_fill_done, D_fill_done, busy}, mem_addr, fill_data);
    end
    obs_n = 0;
    observe(6);
    n_act = 0;
    for (int k = 0; k < 6; k++) if (o_done_i[k] || o_we_i[k] || o_busy[k] || o_en[k]) n_act++;
    total++;
    if (n_act != 0) begin bad++; $display("FAIL rmid_hold: got %0d active cycles want 0", n_act); end
    rst_n = 1'b1;
    obs_n = 0;
    observe(16);
    total++;
    if (o_en[0] !== 1'b1 || o_addr[0] !== 16'h0130) begin
      bad++; $display("FAIL rmid_restart: got en=%b addr=%h want 1 0130", o_en[0], o_addr[0]);
    end
    total++;
    if (o_we_i[5] !== 1'b1 || o_word[5] !== 3'd0 || o_done_i[12] !== 1'b1) begin
      bad++; $display("FAIL rmid_refill: got we=%b word=%0d done@12=%b want 1 0 1", o_we_i[5], o_word[5], o_done_i[12]);
    end
  endtask

  task automatic test_idle_valid();
    int n_act;
    obs_n = 0; inj_valid = 1'b1;
    observe(3);
    inj_valid = 1'b0;
    observe(2);
    n_act = 0;
    for (int k = 0; k < 5; k++) if (o_we_i[k] || o_we_d[k] || o_busy[k] || o_done_i[k] || o_done_d[k]) n_act++;
    total++;
    if (n_act != 0) begin bad++; $display("FAIL idle_valid: got %0d active cycles want 0", n_act); end
  endtask

  task automatic test_deassert();
    int n_we_d, n_we_i_early;
    obs_n = 0; D_miss_addr = 16'h0A16; D_miss = 1'b1;
    observe(3);
    D_miss = 1'b0; D_miss_addr = 16'h7770;
    I_miss_addr = 16'h0C00; I_miss = 1'b1;
    observe(30);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (o_en[k] !== 1'b1 || o_addr[k] !== 16'h0A10 + 16'(2 * k)) begin
        bad++; $display("FAIL deassert_issue[%0d]: got en=%b addr=%h want en=1 addr=%h", k, o_en[k], o_addr[k], 16'h0A10 + 16'(2 * k));
      end
    end
    n_we_d = 0; n_we_i_early = 0;
    for (int k = 0; k < 33; k++) begin
      if (o_we_d[k]) n_we_d++;
      if (o_we_i[k] && k < 14) n_we_i_early++;
    end
    total++;
    if (n_we_d != 8 || o_done_d[12] !== 1'b1) begin
      bad++; $display("FAIL deassert_done: got we_d=%0d done@12=%b want 8 1", n_we_d, o_done_d[12]);
    end
    total++;
    if (n_we_i_early != 0 || o_busy[13] !== 1'b0 || o_en[14] !== 1'b1 || o_addr[14] !== 16'h0C00) begin
      bad++; $display("FAIL deassert_wait: got early_we_i=%0d busy@13=%b en@14=%b addr@14=%h want 0 0 1 0c00", n_we_i_early, o_busy[13], o_en[14], o_addr[14]);
    end
    total++;
    if (o_done_i[26] !== 1'b1) begin bad++; $display("FAIL deassert_i_done: got %b want 1", o_done_i[26]); end
  endtask

  task automatic test_arbitration();
    logic exp_d[3];
    logic [15:0] exp_base;
    exp_d[0] = 1'b1; exp_d[2] = 1'b1;
`ifdef ROUND_ROBIN_EN
    exp_d[1] = 1'b0;
`else
    exp_d[1] = 1'b1;
`endif
    obs_n = 0; auto_drop = 1'b0;
    D_miss_addr = 16'h3000; I_miss_addr = 16'h4000; D_miss = 1'b1; I_miss = 1'b1;
    observe(42);
    D_miss = 1'b0; I_miss = 1'b0; auto_drop = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_base = exp_d[f] ? 16'h3000 : 16'h4000;
      total++;
      if (o_en[14*f] !== 1'b1 || o_addr[14*f] !== exp_base) begin
        bad++; $display("FAIL arb_grant[%0d]: got en=%b addr=%h want en=1 addr=%h", f, o_en[14*f], o_addr[14*f], exp_base);
      end
      total++;
      if (o_we_d[14*f+5] !== exp_d[f] || o_we_i[14*f+5] !== !exp_d[f]) begin
        bad++; $display("FAIL arb_owner[%0d]: got we_d=%b we_i=%b want we_d=%b", f, o_we_d[14*f+5], o_we_i[14*f+5], exp_d[f]);
      end
    end
    obs_n = 0;
    observe(4);
    total++;
    if (o_busy[3] !== 1'b0 || o_en[0] !== 1'b0) begin
      bad++; $display("FAIL arb_release: got busy=%b en=%b want 0 0", o_busy[3], o_en[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_i();
    test_contention();
    test_top_addr();
    test_gap();
    test_reset_mid();
    test_idle_valid();
    test_deassert();
    test_arbitration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
